// File: rtl/spart_bus_arbiter.sv
// Two-master arbiter in front of a SPART register port: picks a requester,
// waits for the SPART to be ready (with optional timeout), and runs a one-cycle bus access.
module spart_bus_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       m0_req,
    input  logic       m0_rw,
    input  logic [1:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_gnt,
    output logic       m0_done,
    output logic       m0_err,

    input  logic       m1_req,
    input  logic       m1_rw,
    input  logic [1:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_gnt,
    output logic       m1_done,
    output logic       m1_err,

    output logic [7:0] rdata,
    output logic       busy,

    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        grant;
    logic        grant_m1;
    logic        ready;
    logic        timeout_hit;

    logic        winner_q;     // 0 = m0, 1 = m1
    logic        last_gnt_q;   // master granted most recently
    logic        rw_q;
    logic [1:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [15:0] cnt_q;
    logic        timed_out_q;

    // Data register is gated by the SPART's FIFO flags; the other registers never stall.
    always_comb begin
        ready = 1'b1;
        if (addr_q == 2'b00) begin
            ready = rw_q ? rda : tbr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_m1    = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant    = 1'b1;
                    grant_m1 = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (ready) begin
                    state_d = ACCESS;
                end else if ((TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1)) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            ACCESS: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q    <= 1'b0;
            last_gnt_q  <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= 2'b00;
            wdata_q     <= 8'h00;
            cnt_q       <= 16'd0;
            timed_out_q <= 1'b0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            m0_gnt <= grant && !grant_m1;
            m1_gnt <= grant && grant_m1;

            if (grant) begin
                winner_q    <= grant_m1;
                last_gnt_q  <= grant_m1;
                rw_q        <= grant_m1 ? m1_rw    : m0_rw;
                addr_q      <= grant_m1 ? m1_addr  : m0_addr;
                wdata_q     <= grant_m1 ? m1_wdata : m0_wdata;
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end

            if (grant || (state_q == DONE)) begin
                cnt_q <= 16'd0;
            end else if ((state_q == WAIT) && !ready && !timeout_hit) begin
                cnt_q <= cnt_q + 16'd1;
            end

            // rdata only changes on reads and aborts; writes leave the last result in place.
            if ((state_q == ACCESS) && rw_q) begin
                rdata <= databus;
            end else if (timeout_hit) begin
                rdata <= 8'h00;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign iocs    = (state_q == ACCESS);
    assign iorw    = (state_q == ACCESS) ? rw_q   : 1'b1;
    assign ioaddr  = (state_q == ACCESS) ? addr_q : 2'b00;
    assign databus = ((state_q == ACCESS) && !rw_q) ? wdata_q : 8'hzz;

    assign m0_done = (state_q == DONE) && !winner_q;
    assign m1_done = (state_q == DONE) &&  winner_q;
    assign m0_err  = m0_done && timed_out_q;
    assign m1_err  = m1_done && timed_out_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Self-checking bench: vector table plus hand sequences, done pulses scored
// against a queue of expected completions.
module tb_spart_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       m0_req = 1'b0, m1_req = 1'b0, m0_rw = 1'b0, m1_rw = 1'b0;
    logic [1:0] m0_addr = 2'b00, m1_addr = 2'b00;
    logic [7:0] m0_wdata = 8'h00, m1_wdata = 8'h00;
    logic       rda = 1'b0, tbr = 1'b0;
    logic [7:0] spart_data = 8'h00;
    logic       m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, busy, iocs, iorw;
    logic [1:0] ioaddr;
    logic [7:0] rdata;
    wire  [7:0] databus;

    assign databus = (iocs && iorw) ? spart_data : 8'hzz;

    spart_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
        .rdata(rdata), .busy(busy), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr)
    );

    // Second instance with a short timeout for the abort path.
    logic       t_req = 1'b0, t_rw = 1'b0;
    logic [1:0] t_addr = 2'b00;
    logic [7:0] t_wdata = 8'h00, t_spart = 8'h00;
    logic       t_m0_gnt, t_m1_gnt, t_m0_done, t_m1_done, t_m0_err, t_m1_err, t_busy, t_iocs, t_iorw;
    logic [1:0] t_ioaddr;
    logic [7:0] t_rdata;
    wire  [7:0] t_databus;

    assign t_databus = (t_iocs && t_iorw) ? t_spart : 8'hzz;

    spart_bus_arbiter #(.TIMEOUT(16'd8)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .m0_req(t_req), .m0_rw(t_rw), .m0_addr(t_addr), .m0_wdata(t_wdata),
        .m0_gnt(t_m0_gnt), .m0_done(t_m0_done), .m0_err(t_m0_err),
        .m1_req(1'b0), .m1_rw(1'b0), .m1_addr(2'b00), .m1_wdata(8'h00),
        .m1_gnt(t_m1_gnt), .m1_done(t_m1_done), .m1_err(t_m1_err),
        .rdata(t_rdata), .busy(t_busy), .iocs(t_iocs), .iorw(t_iorw), .ioaddr(t_ioaddr),
        .databus(t_databus), .rda(1'b0), .tbr(1'b0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       who;
        logic       err;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    typedef struct {
        logic       who;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       rda;
        logic       tbr;
        logic [7:0] spart;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic who;
        int   cyc;
    } gnt_t;

    exp_t sb[$];
    gnt_t glog[$];

    // Monitor: records the bus access of the current transaction and scores each done pulse.
    int         acc_cnt = 0;
    logic       acc_rw = 1'b1;
    logic [1:0] acc_addr = 2'b00;
    logic [7:0] acc_data = 8'h00;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cnt = 0;
        end else begin
            if (m0_gnt || m1_gnt) glog.push_back('{m1_gnt, cyc});
            if (iocs) begin
                acc_cnt++;
                acc_rw   = iorw;
                acc_addr = ioaddr;
                acc_data = databus;
            end
            if (m0_done || m1_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual m0_done=%0b m1_done=%0b required=no done", m0_done, m1_done);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_who", {m1_done, m0_done}, mon_e.who ? 2'b10 : 2'b01);
                    check("err", mon_e.who ? m1_err : m0_err, mon_e.err);
                    check("access_count", acc_cnt, mon_e.err ? 0 : 1);
                    check("rdata", rdata, mon_e.rdata);
                    if (!mon_e.err) begin
                        check("iorw", acc_rw, mon_e.rw);
                        check("ioaddr", acc_addr, mon_e.addr);
                        if (!mon_e.rw) check("write_bus", acc_data, mon_e.wdata);
                    end
                end
                acc_cnt = 0;
            end
        end
    end

    task automatic drive_req(input logic who, input logic val, input logic rw,
                             input logic [1:0] addr, input logic [7:0] wd);
        if (!who) begin
            m0_req = val; m0_rw = rw; m0_addr = addr; m0_wdata = wd;
        end else begin
            m1_req = val; m1_rw = rw; m1_addr = addr; m1_wdata = wd;
        end
    endtask

    function automatic logic done_of(input logic who);
        return who ? m1_done : m0_done;
    endfunction

    task automatic txn(input logic who, input logic rw, input logic [1:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd, input int exp_lat);
        int lat = 0;
        bit seen = 1'b0;
        sb.push_back('{who, 1'b0, rw, addr, wd, exp_rd});
        @(negedge clk);
        drive_req(who, 1'b1, rw, addr, wd);
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("gnt", {m1_gnt, m0_gnt}, who ? 2'b10 : 2'b01);
                check("busy", busy, 1'b1);
            end
            if (lat == 2) check("gnt_pulse", {m1_gnt, m0_gnt}, 2'b00);
            seen = done_of(who);
        end
        check("latency", lat, exp_lat);
        drive_req(who, 1'b0, rw, addr, wd);
    endtask

    task automatic alt_master(input logic who, input logic [7:0] d0, input logic [7:0] d1);
        for (int k = 0; k < 2; k++) begin
            int lat = 0;
            drive_req(who, 1'b1, 1'b0, 2'b00, (k == 0) ? d0 : d1);
            do begin
                @(negedge clk);
                lat++;
            end while (!done_of(who) && lat < 40);
            check("alt_done_seen", done_of(who), 1'b1);
            drive_req(who, 1'b0, 1'b0, 2'b00, (k == 0) ? d0 : d1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   lat;
        int   ios;
        vecs[0] = '{1'b0, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b1, 8'h00, 8'h00, 3};
        vecs[1] = '{1'b0, 1'b0, 2'b10, 8'h15, 1'b0, 1'b0, 8'h00, 8'h00, 3};
        vecs[2] = '{1'b1, 1'b0, 2'b11, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 3};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h5A, 8'h5A, 3};
        vecs[4] = '{1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 1'b0, 8'hC3, 8'hC3, 3};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 8'h66, 1'b0, 1'b1, 8'h00, 8'hC3, 3};
        vecs[6] = '{1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 8'h81, 8'h81, 3};
        vecs[7] = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'h0F, 8'h0F, 3};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pulses", {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err}, 6'b0);
        check("rst_io", {iocs, iorw, ioaddr}, 4'b0100);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy", busy, 1'b0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rda        = vecs[i].rda;
            tbr        = vecs[i].tbr;
            spart_data = vecs[i].spart;
            txn(vecs[i].who, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_lat);
        end

        // m1 read of data register stalls until rda rises; rda falling during ACCESS is harmless.
        rda = 1'b0; tbr = 1'b0; spart_data = 8'h3C;
        fork
            txn(1'b1, 1'b1, 2'b00, 8'h00, 8'h3C, 12);
            begin
                repeat (11) @(negedge clk);
                rda = 1'b1;
                @(negedge clk);
                rda = 1'b0;
            end
        join

        // Reset asserted in the middle of an ACCESS cycle.
        tbr = 1'b1;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 2'b00, 8'h77);
        @(negedge clk);
        check("rst_seq_gnt", m0_gnt, 1'b1);
        @(negedge clk);
        check("rst_seq_access", iocs, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_iocs", iocs, 1'b0);
        check("rst_async_iorw", iorw, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_rdata", rdata, 8'h00);
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 8'h77);
        @(negedge clk);
        check("rst_no_done", {m1_done, m0_done}, 2'b00);
        #3 rst_n = 1'b1;
        spart_data = 8'h99;
        txn(1'b1, 1'b1, 2'b01, 8'h00, 8'h99, 3);

        // Both masters request continuously: grants alternate every 4 cycles.
        tbr = 1'b1;
        glog.delete();
        sb.push_back('{1'b0, 1'b0, 1'b0, 2'b00, 8'h11, 8'h99});
        sb.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 8'h33, 8'h99});
        sb.push_back('{1'b0, 1'b0, 1'b0, 2'b00, 8'h22, 8'h99});
        sb.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 8'h44, 8'h99});
        @(negedge clk);
        fork
            alt_master(1'b0, 8'h11, 8'h22);
            alt_master(1'b1, 8'h33, 8'h44);
        join
        check("alt_grant_count", glog.size(), 4);
        for (int i = 0; i < glog.size() && i < 4; i++) begin
            check("alt_grant_who", glog[i].who, i % 2);
            if (i > 0) check("alt_grant_spacing", glog[i].cyc - glog[i-1].cyc, 4);
        end

        // Timeout instance: a read to set rdata, then a write that can never become ready.
        @(negedge clk);
        t_spart = 8'hEE; t_req = 1'b1; t_rw = 1'b1; t_addr = 2'b01;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!t_m0_done && lat < 40);
        check("to_read_latency", lat, 3);
        check("to_read_rdata", t_rdata, 8'hEE);
        t_req = 1'b0;
        @(negedge clk);
        t_req = 1'b1; t_rw = 1'b0; t_addr = 2'b00; t_wdata = 8'h5A;
        lat = 0; ios = 0;
        do begin
            @(negedge clk);
            lat++;
            if (t_iocs) ios++;
        end while (!t_m0_done && lat < 40);
        t_req = 1'b0;
        check("to_latency", lat, 9);
        check("to_err", t_m0_err, 1'b1);
        check("to_other_done", {t_m1_done, t_m1_err, t_m1_gnt}, 3'b000);
        check("to_no_iocs", ios, 0);
        check("to_rdata", t_rdata, 8'h00);
        @(negedge clk);
        check("to_idle", t_busy, 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
